// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path types and defaults.
// Package uart_pkg: byte width, default FIFO depth, drop counter width, byte type.
package uart_pkg;

   localparam int UART_DATA_W         = 8;
   localparam int UART_FIFO_DEPTH_DEF = 16;
   localparam int UART_DROP_CNT_W     = 8;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver/reader-facing bundle of the UART receive FIFO.
// master: drives rx_status/rx_data/rd_en/ovf_clr; slave: the FIFO side.
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_FIFO_DEPTH_DEF,
   parameter int DATA_W = UART_DATA_W
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic                       rx_status;
   logic [DATA_W-1:0]          rx_data;
   logic                       rd_en;
   logic [DATA_W-1:0]          rd_data;
   logic                       rd_valid;
   logic                       empty;
   logic                       full;
   logic [CW-1:0]              count;
   logic                       overflow;
   logic [UART_DROP_CNT_W-1:0] drop_cnt;
   logic                       ovf_clr;

   modport master (
      output rx_status, rx_data, rd_en, ovf_clr,
      input  rd_data, rd_valid, empty, full,
      input  count, overflow, drop_cnt
   );

   modport slave (
      input  rx_status, rx_data, rd_en, ovf_clr,
      output rd_data, rd_valid, empty, full,
      output count, overflow, drop_cnt
   );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_W byte store: synchronous write port, asynchronous read port.
// Ports: i_clk, i_we, i_waddr, i_wdata, i_raddr, o_rdata.
module uart_fifo_mem #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Circular receive buffer behind the UART receiver with occupancy and drop stats.
// Ports: smp_clk, reset (sync, active-high), bus (uart_rx_fifo_if.slave).
// Option UART_RX_FIFO_FWFT_EN: first-word-fall-through read; else registered read.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_FIFO_DEPTH_DEF,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic         smp_clk,
   input  logic         reset,
   uart_rx_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = UART_DROP_CNT_W;

   localparam logic [AW-1:0] LP_PTR1 = AW'(1);
   localparam logic [CW-1:0] LP_CNT1 = CW'(1);
   localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);
   localparam logic [DW-1:0] LP_DRP1 = DW'(1);

   logic [AW-1:0]     r_wp;
   logic [AW-1:0]     r_rp;
   logic [CW-1:0]     r_count;
   logic              r_empty;
   logic              r_full;
   logic              r_overflow;
   logic [DW-1:0]     r_drop_cnt;

   logic              w_pop;
   logic              w_wr;
   logic              w_drop;
   logic              w_we;
   logic [CW-1:0]     w_count_nxt;
   logic [DATA_W-1:0] w_rdata;

   // A pop frees the slot in the same cycle, so a full buffer still
   // accepts a write alongside it; an empty buffer never pops.
   assign w_pop  = bus.rd_en && !r_empty;
   assign w_wr   = bus.rx_status && (!r_full || w_pop);
   assign w_drop = bus.rx_status && r_full && !w_pop;
   assign w_we   = w_wr && !reset;

   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_wr, w_pop})
         2'b10:   w_count_nxt = r_count + LP_CNT1;
         2'b01:   w_count_nxt = r_count - LP_CNT1;
         default: w_count_nxt = r_count;
      endcase
   end

   uart_fifo_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_mem (
      .i_clk   (smp_clk),
      .i_we    (w_we),
      .i_waddr (r_wp),
      .i_wdata (bus.rx_data),
      .i_raddr (r_rp),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge smp_clk) begin
      if (reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wp <= r_wp + LP_PTR1;
         end
         if (w_pop) begin
            r_rp <= r_rp + LP_PTR1;
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == LP_FULL);
      end
   end

   // A drop coinciding with a clear restarts the tally at one.
   always_ff @(posedge smp_clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (bus.ovf_clr) begin
            r_drop_cnt <= LP_DRP1;
         end else if (r_drop_cnt != '1) begin
            r_drop_cnt <= r_drop_cnt + LP_DRP1;
         end
      end else if (bus.ovf_clr) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end
   end

`ifdef UART_RX_FIFO_FWFT_EN
   assign bus.rd_data  = w_rdata;
   assign bus.rd_valid = !r_empty;
`else
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;

   always_ff @(posedge smp_clk) begin
      if (reset) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_pop;
         if (w_pop) begin
            r_rd_data <= w_rdata;
         end
      end
   end

   assign bus.rd_data  = r_rd_data;
   assign bus.rd_valid = r_rd_valid;
`endif

   assign bus.count    = r_count;
   assign bus.empty    = r_empty;
   assign bus.full     = r_full;
   assign bus.overflow = r_overflow;
   assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model,
// per-cycle compare process, directed cases plus randomized traffic.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int DEPTH = 16;

   logic smp_clk = 1'b0;
   logic reset   = 1'b1;

   uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(8)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
      .smp_clk (smp_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 smp_clk = ~smp_clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   uart_byte_t q[$];
   uart_byte_t rdlog[$];
   bit         m_init = 0;
   bit         m_ovf  = 0;
   int         m_drop = 0;
   uart_byte_t m_rd_data = 8'h00;
   bit         m_rd_valid = 0;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
      end
   endtask

   always @(posedge smp_clk) begin
      bit pop;
      bit was_full;
      uart_byte_t b;
      if (reset) begin
         m_init = 1;
         q.delete();
         m_ovf = 0;
         m_drop = 0;
         m_rd_data = 8'h00;
         m_rd_valid = 0;
      end else begin
         pop = bus.rd_en && (q.size() > 0);
         was_full = (q.size() == DEPTH);
         m_rd_valid = 0;
         if (pop) begin
            b = q.pop_front();
            rdlog.push_back(b);
            m_rd_data = b;
            m_rd_valid = 1;
         end
         if (bus.rx_status && was_full && !pop) begin
            m_ovf = 1;
            m_drop = bus.ovf_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
         end else begin
            if (bus.rx_status) q.push_back(bus.rx_data);
            if (bus.ovf_clr) begin
               m_ovf = 0;
               m_drop = 0;
            end
         end
      end
   end

   always @(negedge smp_clk) begin
      if (m_init) begin
         chk("count", bus.count, q.size());
         chk("empty", bus.empty, q.size() == 0);
         chk("full", bus.full, q.size() == DEPTH);
         chk("overflow", bus.overflow, m_ovf);
         chk("drop_cnt", bus.drop_cnt, m_drop);
`ifdef UART_RX_FIFO_FWFT_EN
         chk("rd_valid", bus.rd_valid, q.size() != 0);
         if (q.size() != 0) chk("rd_data", bus.rd_data, q[0]);
`else
         chk("rd_valid", bus.rd_valid, m_rd_valid);
         chk("rd_data", bus.rd_data, m_rd_data);
`endif
      end
   end

   task automatic step(input bit rx, input logic [7:0] d, input bit rd,
                       input bit clr = 0, input bit rst = 0);
      @(negedge smp_clk);
      #1;
      bus.rx_status = rx;
      bus.rx_data   = d;
      bus.rd_en     = rd;
      bus.ovf_clr   = clr;
      reset         = rst;
   endtask

   task automatic idle();
      step(0, 8'h00, 0);
   endtask

   initial begin
      bit seen99;
      bus.rx_status = 0;
      bus.rx_data   = 0;
      bus.rd_en     = 0;
      bus.ovf_clr   = 0;
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      idle();
      chk("rst_count", bus.count, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_valid", bus.rd_valid, 0);

      // Three bytes in, three out in order
      rdlog.delete();
      step(1, 8'h41, 0);
      step(1, 8'h42, 0);
      step(1, 8'h43, 0);
      idle();
      chk("t1_count", bus.count, 3);
      chk("t1_empty", bus.empty, 0);
      repeat (3) step(0, 0, 1);
      idle();
      chk("t1_empty_after", bus.empty, 1);
      chk("t1_n", rdlog.size(), 3);
      if (rdlog.size() == 3) begin
         chk("t1_b0", rdlog[0], 8'h41);
         chk("t1_b1", rdlog[1], 8'h42);
         chk("t1_b2", rdlog[2], 8'h43);
      end

      // Fill, then drop 0x99
      for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom_range(0, 255)) & 8'h7f, 0);
      step(1, 8'h99, 0);
      idle();
      chk("t2_full", bus.full, 1);
      chk("t2_ovf", bus.overflow, 1);
      chk("t2_drop", bus.drop_cnt, 1);

      // Full with simultaneous write and pop
      rdlog.delete();
      step(1, 8'h55, 1);
      idle();
      chk("t3_count", bus.count, 16);
      repeat (DEPTH) step(0, 0, 1);
      idle();
      chk("t3_n", rdlog.size(), 17);
      if (rdlog.size() == 17) chk("t3_last", rdlog[16], 8'h55);
      seen99 = 0;
      foreach (rdlog[i]) if (rdlog[i] == 8'h99) seen99 = 1;
      chk("t3_no99", seen99, 0);

      // Empty with simultaneous write and pop
      rdlog.delete();
      step(1, 8'h7E, 1);
      idle();
      chk("t4_count", bus.count, 1);
      step(0, 0, 1);
      idle();
      chk("t4_n", rdlog.size(), 1);
      if (rdlog.size() == 1) chk("t4_b", rdlog[0], 8'h7E);
      step(0, 0, 1);
      idle();
      chk("t4_cnt0", bus.count, 0);

      // 40 bytes through two pointer wraps
      rdlog.delete();
      for (int i = 0; i < 40; i++) step(1, 8'(i), i > 0);
      step(0, 0, 1);
      idle();
      chk("t5_n", rdlog.size(), 40);
      if (rdlog.size() == 40)
         for (int i = 0; i < 40; i++) chk("t5_b", rdlog[i], i);

      // Saturating drop counter and clears
      for (int i = 0; i < DEPTH; i++) step(1, 8'(i + 8'h20), 0);
      for (int i = 0; i < 300; i++) step(1, 8'hEE, 0);
      idle();
      chk("t5_sat", bus.drop_cnt, 255);
      step(1, 8'hEF, 0, 1);
      idle();
      chk("t5_clrdrop_cnt", bus.drop_cnt, 1);
      chk("t5_clrdrop_ovf", bus.overflow, 1);
      step(0, 0, 0, 1);
      idle();
      chk("t5_clr_ovf", bus.overflow, 0);
      chk("t5_clr_cnt", bus.drop_cnt, 0);

      // Random traffic: write-heavy then read-heavy
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 2) != 0, 8'($urandom()),
              $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 3) == 0, 8'($urandom()),
              $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);

      // Reset mid-stream with a strobe in the reset cycle
      repeat (DEPTH + 2) step(0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 8'(8'hA0 + i), 0);
      step(0, 0, 1);
      idle();
      step(1, 8'hAA, 0, 0, 1);
      idle();
      chk("t6_count", bus.count, 0);
      chk("t6_empty", bus.empty, 1);
      chk("t6_full", bus.full, 0);
      chk("t6_ovf", bus.overflow, 0);
      chk("t6_drop", bus.drop_cnt, 0);
      chk("t6_valid", bus.rd_valid, 0);
`ifndef UART_RX_FIFO_FWFT_EN
      chk("t6_rdata", bus.rd_data, 0);
`endif
      idle();
      idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
